// File: rtl/line_pkg.sv
// rtl/line_pkg.sv - shared line-drawing types and defaults
// Used by line_gen, projection and line_pixel_writer.
//   X_W / Y_W          : pixel coordinate widths
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default active raster size
//   point_t            : one rasterised pixel {x, y}
//   wr_state_t         : frame-buffer writer state
package line_pkg;

    localparam int X_W          = 11;
    localparam int Y_W          = 10;
    localparam int H_ACTIVE_DEF = 1280;
    localparam int V_ACTIVE_DEF = 720;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } point_t;

    typedef enum logic {
        CLEAR = 1'b0,
        DRAW  = 1'b1
    } wr_state_t;

endpackage

// File: rtl/line_pixel_writer_if.sv
// rtl/line_pixel_writer_if.sv - point stream, BRAM write port and status bundle
// Signals:
//   x_in, y_in, data_valid_in, ready_out : point stream from line_gen
//   frame_start_in                       : frame restart pulse
//   mem_ready_in, addr_out, wdata_out, we_out : BRAM write port
//   busy_out, clear_done_out, clip_count_out  : status
// Modports: master = upstream/memory side, slave = line_pixel_writer.
interface line_pixel_writer_if #(
    parameter int ADDR_W = 20
);
    import line_pkg::*;

    logic [X_W-1:0]    x_in;
    logic [Y_W-1:0]    y_in;
    logic              data_valid_in;
    logic              ready_out;
    logic              frame_start_in;
    logic              mem_ready_in;
    logic [ADDR_W-1:0] addr_out;
    logic              wdata_out;
    logic              we_out;
    logic              busy_out;
    logic              clear_done_out;
    logic [15:0]       clip_count_out;

    modport master (
        output x_in, y_in, data_valid_in, frame_start_in, mem_ready_in,
        input  ready_out, addr_out, wdata_out, we_out,
               busy_out, clear_done_out, clip_count_out
    );

    modport slave (
        input  x_in, y_in, data_valid_in, frame_start_in, mem_ready_in,
        output ready_out, addr_out, wdata_out, we_out,
               busy_out, clear_done_out, clip_count_out
    );

endinterface

// File: rtl/point_fifo.sv
// rtl/point_fifo.sv - synchronous FIFO of point_t with full/empty flags
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : synchronous flush (drops all entries)
//   push, din    : write side, ignored when full
//   pop, dout    : read side, dout shows head entry, pop ignored when empty
//   full, empty  : status flags
module point_fifo
    import line_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   push,
    input  point_t din,
    output logic   full,
    input  logic   pop,
    output point_t dout,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);

    point_t        mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/line_pixel_writer.sv
// rtl/line_pixel_writer.sv - writes line_gen pixels into a 1-bit overlay frame buffer
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus (slave)    : point stream in, BRAM write port out, status out
// Behaviour: sweep-clears the buffer after reset / frame_start, then draws
// accepted points through FIFO -> clip -> address -> output register.
module line_pixel_writer
    import line_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    line_pixel_writer_if.slave bus
);

    localparam int                TOTAL     = H_ACTIVE * V_ACTIVE;
    localparam int                ADDR_W    = $clog2(TOTAL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] H_MUL     = ADDR_W'(H_ACTIVE);

    wr_state_t         state;
    logic [ADDR_W-1:0] ptr;

    point_t            fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              pop_clipped;

    logic              s1_valid;
    point_t            s1_pt;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W-1:0] s1_addr;
    logic [15:0]       clip_count;

    logic              flush;
    logic              out_en;
    logic              s1_en;
    logic              ready;
    logic              clear_last;

    assign flush = rst_in || bus.frame_start_in;

    // Stages advance like a skid-free pipeline: each moves when the one
    // below it is empty or moving.
    assign out_en = !out_valid || bus.mem_ready_in;
    assign s1_en  = !s1_valid || out_en;

    assign ready = (state == DRAW) && !fifo_full && !bus.frame_start_in;
    assign push  = bus.data_valid_in && ready;
    assign pop   = (state == DRAW) && !fifo_empty && s1_en;

    assign pop_clipped = (int'(fifo_dout.x) >= H_ACTIVE) || (int'(fifo_dout.y) >= V_ACTIVE);
    assign s1_addr     = ADDR_W'(s1_pt.y) * H_MUL + ADDR_W'(s1_pt.x);
    assign clear_last  = (state == CLEAR) && (ptr == LAST_ADDR);

    point_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .clear (bus.frame_start_in),
        .push  (push),
        .din   ({bus.x_in, bus.y_in}),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk_in) begin
        if (flush) begin
            state      <= CLEAR;
            ptr        <= '0;
            s1_valid   <= 1'b0;
            s1_pt      <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            clip_count <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (bus.mem_ready_in) begin
                        if (clear_last) begin
                            state <= DRAW;
                            ptr   <= '0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                DRAW: begin
                    if (out_en) begin
                        out_valid <= s1_valid;
                        out_addr  <= s1_addr;
                    end
                    if (s1_en) begin
                        s1_valid <= pop && !pop_clipped;
                        s1_pt    <= fifo_dout;
                    end
                    if (pop && pop_clipped && (clip_count != 16'hFFFF)) begin
                        clip_count <= clip_count + 16'd1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Clear-sweep outputs decode directly from state/ptr so the first write
    // of address 0 appears in the first cycle after reset or frame_start;
    // rst_in gates them so everything reads 0 while reset is held.
    assign bus.ready_out      = ready;
    assign bus.we_out         = !rst_in && ((state == CLEAR) || out_valid);
    assign bus.wdata_out      = !rst_in && (state == DRAW) && out_valid;
    assign bus.addr_out       = rst_in ? '0 : ((state == CLEAR) ? ptr : out_addr);
    assign bus.busy_out       = !rst_in && (state == CLEAR);
    assign bus.clear_done_out = !rst_in && clear_last && bus.mem_ready_in && !bus.frame_start_in;
    assign bus.clip_count_out = rst_in ? 16'd0 : clip_count;

endmodule
